// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time sysid checker: reads the sysid ID and timestamp words, compares them with
// build-time constants, retries a bounded number of times and reports on an Avalon-MM status slave.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1519654004,
    parameter int unsigned SETTLE_CYCLES      = 4,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic [1:0]  retry_count,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        READ_ID = 3'd2,
        READ_TS = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

    state_t     state;
    logic [7:0] settle_cnt;
    logic       auto_pending;
    logic       start_req;
    logic       id_ok;
    logic       ts_ok;

    // auto_pending is high only before the first edge after reset release.
    assign start_req = start | auto_pending |
                       (avs_write && (avs_address == 2'd3) && avs_writedata[0]);
    assign id_ok     = (captured_id == EXPECTED_ID);
    assign ts_ok     = (captured_ts == EXPECTED_TIMESTAMP);
    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            settle_cnt    <= 8'd0;
            auto_pending  <= AUTO_START;
            sysid_address <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            id_mismatch   <= 1'b0;
            ts_mismatch   <= 1'b0;
            retry_count   <= 2'd0;
            captured_id   <= 32'd0;
            captured_ts   <= 32'd0;
            avs_readdata  <= 32'd0;
        end else begin
            auto_pending <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_req) begin
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        id_mismatch   <= 1'b0;
                        ts_mismatch   <= 1'b0;
                        retry_count   <= 2'd0;
                        settle_cnt    <= SETTLE_LOAD;
                        busy          <= 1'b1;
                        sysid_address <= 1'b0;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        state <= READ_ID;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                READ_ID: begin
                    captured_id   <= sysid_readdata;
                    sysid_address <= 1'b1;
                    state         <= READ_TS;
                end
                READ_TS: begin
                    captured_ts   <= sysid_readdata;
                    sysid_address <= 1'b0;
                    state         <= COMPARE;
                end
                COMPARE: begin
                    id_mismatch <= !id_ok;
                    ts_mismatch <= !ts_ok;
                    if (id_ok && ts_ok) begin
                        pass  <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (retry_count < RETRY_LIMIT) begin
                        retry_count <= retry_count + 2'd1;
                        settle_cnt  <= SETTLE_LOAD;
                        state       <= SETTLE;
                    end else begin
                        pass  <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Read latency 1: data registered on the strobe edge and held until the next read.
            if (avs_read) begin
                case (avs_address)
                    2'd0:    avs_readdata <= {25'd0, retry_count, ts_mismatch, id_mismatch,
                                              pass, done, busy};
                    2'd1:    avs_readdata <= captured_id;
                    2'd2:    avs_readdata <= captured_ts;
                    default: avs_readdata <= 32'd0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench for the sysid checker: scenario table plus hand sequences for retries,
// ignored starts, mid-check reset and the status slave.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1519654004;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] id_val = 32'd0;
    logic [31:0] ts_val = TS_GOOD;

    logic        sysid_address, busy, done, pass, id_mismatch, ts_mismatch;
    logic [1:0]  retry_count;
    logic [31:0] sysid_readdata, captured_id, captured_ts, avs_readdata;
    logic [2:0]  dbg_state;

    logic        d0_address, d0_busy, d0_done, d0_pass, d0_idm, d0_tsm;
    logic [1:0]  d0_retry;
    logic [31:0] d0_readdata, d0_cid, d0_cts, d0_avs;
    logic [2:0]  d0_state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Sysid slave model: combinational read of the selected word.
    assign sysid_readdata = sysid_address ? ts_val : id_val;
    assign d0_readdata    = d0_address ? ts_val : id_val;

    first_nios2_system_sysid_checker #(.AUTO_START(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .sysid_address(sysid_address),
        .sysid_readdata(sysid_readdata), .start(start), .busy(busy), .done(done),
        .pass(pass), .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch),
        .retry_count(retry_count), .captured_id(captured_id), .captured_ts(captured_ts),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .dbg_state(dbg_state)
    );

    first_nios2_system_sysid_checker #(.AUTO_START(1'b0)) dut0 (
        .clock(clock), .reset_n(reset_n), .sysid_address(d0_address),
        .sysid_readdata(d0_readdata), .start(1'b0), .busy(d0_busy), .done(d0_done),
        .pass(d0_pass), .id_mismatch(d0_idm), .ts_mismatch(d0_tsm),
        .retry_count(d0_retry), .captured_id(d0_cid), .captured_ts(d0_cts),
        .avs_address(2'd0), .avs_read(1'b0), .avs_write(1'b0),
        .avs_writedata(32'd0), .avs_readdata(d0_avs), .dbg_state(d0_state)
    );

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        int          edges;
        logic        exp_pass;
        logic        exp_idm;
        logic        exp_tsm;
        logic [1:0]  exp_retry;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start so it is sampled at the next edge; returns just after that edge.
    task automatic launch();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("launch_busy", {31'd0, busy}, 32'd1);
        check("launch_done_clear", {31'd0, done}, 32'd0);
    endtask

    // Count edges until done; optionally pulse start at p1/p2 and switch the ID word at sw.
    task automatic wait_done(input int p1, input int p2, input int sw, output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (done) break;
            start = (n == p1) || (n == p2);
            if (n == sw) id_val = 32'd0;
        end
        start = 1'b0;
        if (!done) check("wait_done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic avs_rd(input logic [1:0] addr, input string name, input logic [31:0] exp);
        @(negedge clock);
        avs_address = addr;
        avs_read    = 1'b1;
        @(posedge clock);
        #1;
        avs_read = 1'b0;
        check(name, avs_readdata, exp);
    endtask

    task automatic avs_wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clock);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(posedge clock);
        #1;
        avs_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{32'd0, TS_GOOD,          7,  1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{32'd0, 32'd1519654005,   28, 1'b0, 1'b0, 1'b1, 2'd3};
        vecs[2] = '{32'd7, TS_GOOD,          28, 1'b0, 1'b1, 1'b0, 2'd3};
        vecs[3] = '{32'd7, 32'd0,            28, 1'b0, 1'b1, 1'b1, 2'd3};
        vecs[4] = '{32'd0, TS_GOOD,          7,  1'b1, 1'b0, 1'b0, 2'd0};

        // Reset state
        #23;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {31'd0, sysid_address}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        check("rst_avs", avs_readdata, 32'd0);

        // Auto start on the first edge after release
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("auto_busy", {31'd0, busy}, 32'd1);
        check("auto_state", {29'd0, dbg_state}, 32'd1);
        check("noauto_busy", {31'd0, d0_busy}, 32'd0);
        wait_done(-1, -1, -1, n);
        check("auto_edges", n, 32'd7);
        check("auto_pass", {31'd0, pass}, 32'd1);
        check("auto_retry", {30'd0, retry_count}, 32'd0);
        check("auto_cts", captured_ts, TS_GOOD);
        check("noauto_state", {29'd0, d0_state}, 32'd0);

        // Scenario table
        for (int i = 0; i < 5; i++) begin
            id_val = vecs[i].id;
            ts_val = vecs[i].ts;
            launch();
            wait_done(-1, -1, -1, n);
            check($sformatf("v%0d_edges", i), n, vecs[i].edges);
            check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
            check($sformatf("v%0d_idm", i), {31'd0, id_mismatch}, {31'd0, vecs[i].exp_idm});
            check($sformatf("v%0d_tsm", i), {31'd0, ts_mismatch}, {31'd0, vecs[i].exp_tsm});
            check($sformatf("v%0d_retry", i), {30'd0, retry_count}, {30'd0, vecs[i].exp_retry});
            check($sformatf("v%0d_cid", i), captured_id, vecs[i].id);
            check($sformatf("v%0d_cts", i), captured_ts, vecs[i].ts);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // First pass reads a wrong ID, the retry reads the right one
        id_val = 32'd5;
        ts_val = TS_GOOD;
        launch();
        wait_done(-1, -1, 5, n);
        check("retry1_edges", n, 32'd14);
        check("retry1_pass", {31'd0, pass}, 32'd1);
        check("retry1_count", {30'd0, retry_count}, 32'd1);
        check("retry1_idm", {31'd0, id_mismatch}, 32'd0);
        check("retry1_cid", captured_id, 32'd0);

        // Starts during SETTLE and on the COMPARE->DONE edge are ignored
        launch();
        wait_done(2, 6, -1, n);
        check("ignore_edges", n, 32'd7);
        repeat (3) @(posedge clock);
        #1;
        check("ignore_still_done", {31'd0, done}, 32'd1);
        check("ignore_not_busy", {31'd0, busy}, 32'd0);

        // Status slave
        avs_rd(2'd0, "avs_status", 32'h6);
        avs_rd(2'd1, "avs_cid", 32'd0);
        avs_rd(2'd2, "avs_cts", TS_GOOD);
        avs_rd(2'd3, "avs_addr3", 32'd0);
        @(posedge clock);
        #1;
        check("avs_hold", avs_readdata, 32'd0);
        avs_rd(2'd2, "avs_cts2", TS_GOOD);
        @(posedge clock);
        #1;
        check("avs_hold2", avs_readdata, TS_GOOD);
        avs_wr(2'd0, 32'd1);
        check("avs_wr0_ignored", {31'd0, busy}, 32'd0);
        avs_wr(2'd3, 32'd0);
        check("avs_wr3_zero_ignored", {31'd0, busy}, 32'd0);
        avs_wr(2'd3, 32'd1);
        check("avs_start_done_clear", {31'd0, done}, 32'd0);
        avs_rd(2'd0, "avs_busy_bit", 32'h1);
        wait_done(-1, -1, -1, n);
        check("avs_start_edges", n, 32'd6);

        // Reset in the middle of READ_TS
        id_val = 32'h1234;
        launch();
        repeat (5) @(posedge clock);
        #1;
        check("rts_state", {29'd0, dbg_state}, 32'd3);
        check("rts_addr", {31'd0, sysid_address}, 32'd1);
        check("rts_cid", captured_id, 32'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", {29'd0, dbg_state}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_addr", {31'd0, sysid_address}, 32'd0);
        check("arst_cid", captured_id, 32'd0);
        check("arst_cts", captured_ts, 32'd0);
        check("arst_avs", avs_readdata, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        id_val = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        wait_done(-1, -1, -1, n);
        check("rerun_edges", n, 32'd7);
        check("rerun_pass", {31'd0, pass}, 32'd1);
        check("noauto2_busy", {31'd0, d0_busy}, 32'd0);
        check("noauto2_done", {31'd0, d0_done}, 32'd0);
        check("noauto2_state", {29'd0, d0_state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
